// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer: FIFO of dirty-line writebacks and uncached stores, issued to the
// bridge one at a time; each entry is retired only on data_wr_ok.
module dcache_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic         push_uncached,
    input  logic [31:0]  push_addr,
    input  logic [2:0]   push_size,
    input  logic [3:0]   push_wstrb,
    input  logic [127:0] push_data,
    input  logic [31:0]  chk_addr,
    output logic         chk_hit,
    output logic         wb_empty,
    output logic         data_wr_req,
    output logic [2:0]   data_wr_type,
    output logic [31:0]  data_wr_addr,
    output logic [2:0]   data_wr_size,
    output logic [3:0]   data_wr_wstrb,
    output logic [127:0] data_wr_data,
    input  logic         data_wr_rdy,
    input  logic         data_wr_ok
);
    typedef enum logic [2:0] {S_IDLE = 3'b001, S_REQ = 3'b010, S_WAIT = 3'b100} state_t;
    state_t state, state_n;
    logic [PTR_W-1:0] head, tail, idx;
    logic [PTR_W:0]   count;
    logic             ent_unc   [DEPTH];
    logic [31:0]      ent_addr  [DEPTH];
    logic [2:0]       ent_size  [DEPTH];
    logic [3:0]       ent_wstrb [DEPTH];
    logic [127:0]     ent_data  [DEPTH];
    logic             push_fire, retire;

    assign push_ready    = count != (PTR_W+1)'(DEPTH);
    assign push_fire     = push_valid && push_ready;
    assign retire        = (state == S_WAIT) && data_wr_ok;
    assign wb_empty      = (count == '0) && (state == S_IDLE);
    assign data_wr_req   = state == S_REQ;
    assign data_wr_type  = ent_unc[head] ? 3'b010 : 3'b100;
    assign data_wr_addr  = ent_unc[head] ? ent_addr[head] : {ent_addr[head][31:4], 4'h0};
    assign data_wr_size  = ent_unc[head] ? ent_size[head] : 3'd2;
    assign data_wr_wstrb = ent_unc[head] ? ent_wstrb[head] : 4'b1111;
    assign data_wr_data  = ent_data[head];

    always_comb begin
        state_n = (state == S_IDLE) ? ((count != '0) ? S_REQ : S_IDLE) :
                  (state == S_REQ)  ? (data_wr_rdy ? S_WAIT : S_REQ) :
                  (state == S_WAIT) ? (data_wr_ok ? S_IDLE : S_WAIT) : S_IDLE;
    end

    // Line entries compare on the 16 B line, uncached entries on the 4 B word
    always_comb begin
        chk_hit = 1'b0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((PTR_W+1)'(i) < count &&
                ((chk_addr ^ ent_addr[idx]) & (ent_unc[idx] ? 32'hFFFF_FFFC : 32'hFFFF_FFF0)) == '0)
                chk_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            if (push_fire) tail <= tail + PTR_W'(1);
            if (retire) head <= head + PTR_W'(1);
            count <= count + (PTR_W+1)'(push_fire) - (PTR_W+1)'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            ent_unc[tail]   <= push_uncached;
            ent_addr[tail]  <= push_addr;
            ent_size[tail]  <= push_size;
            ent_wstrb[tail] <= push_wstrb;
            ent_data[tail]  <= push_data;
        end
    end
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb_dcache_wb_buffer: directed table vectors, corner sequences and a randomized run
// against a queue-based reference model of the write-back buffer.
module tb_dcache_wb_buffer;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         push_valid, push_ready, push_uncached;
    logic [31:0]  push_addr;
    logic [2:0]   push_size;
    logic [3:0]   push_wstrb;
    logic [127:0] push_data;
    logic [31:0]  chk_addr;
    logic         chk_hit, wb_empty, data_wr_req;
    logic [2:0]   data_wr_type, data_wr_size;
    logic [31:0]  data_wr_addr;
    logic [3:0]   data_wr_wstrb;
    logic [127:0] data_wr_data;
    logic         data_wr_rdy, data_wr_ok;

    dcache_wb_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_uncached(push_uncached),
        .push_addr(push_addr), .push_size(push_size), .push_wstrb(push_wstrb),
        .push_data(push_data), .chk_addr(chk_addr), .chk_hit(chk_hit), .wb_empty(wb_empty),
        .data_wr_req(data_wr_req), .data_wr_type(data_wr_type), .data_wr_addr(data_wr_addr),
        .data_wr_size(data_wr_size), .data_wr_wstrb(data_wr_wstrb), .data_wr_data(data_wr_data),
        .data_wr_rdy(data_wr_rdy), .data_wr_ok(data_wr_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         unc;
        logic [31:0]  addr;
        logic [2:0]   size;
        logic [3:0]   wstrb;
        logic [127:0] data;
    } ent_t;

    typedef struct {
        ent_t        e;
        logic [2:0]  x_type;
        logic [31:0] x_addr;
        logic [2:0]  x_size;
        logic [3:0]  x_wstrb;
    } vec_t;

    int   n_chk = 0;
    int   n_err = 0;
    ent_t q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_push(input ent_t e);
        push_valid    = 1'b1;
        push_uncached = e.unc;
        push_addr     = e.addr;
        push_size     = e.size;
        push_wstrb    = e.wstrb;
        push_data     = e.data;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !data_wr_req; i++) @(negedge clk);
        chk("req_seen", data_wr_req, 1'b1);
    endtask

    // Grant the pending request, then pulse ok right after; returns at the negedge after retire
    task automatic finish_one();
        data_wr_rdy = 1'b1;
        @(negedge clk);
        data_wr_rdy = 1'b0;
        data_wr_ok  = 1'b1;
        @(negedge clk);
        data_wr_ok  = 1'b0;
    endtask

    function automatic logic [2:0] m_type(input ent_t e);
        return e.unc ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [31:0] m_addr(input ent_t e);
        return e.unc ? e.addr : {e.addr[31:4], 4'h0};
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
        foreach (q[k]) begin
            if (q[k].unc ? (a[31:2] == q[k].addr[31:2]) : (a[31:4] == q[k].addr[31:4])) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[5];
        ent_t        e;
        logic [31:0] got[5];
        logic        outstanding, prev_retire, grant, retire, pushed;
        int          timer, stall;

        reset = 1'b1; push_valid = 1'b0; push_uncached = 1'b0; push_addr = '0;
        push_size = '0; push_wstrb = '0; push_data = '0; chk_addr = '0;
        data_wr_rdy = 1'b0; data_wr_ok = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", data_wr_req, 1'b0);
        chk("rst_ready", push_ready, 1'b1);
        chk("rst_hit", chk_hit, 1'b0);
        chk("rst_empty", wb_empty, 1'b1);
        reset = 1'b0;

        tbl[0] = '{'{1'b0, 32'h1000_0014, 3'd5, 4'h1, 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF},
                   3'b100, 32'h1000_0010, 3'd2, 4'hF};
        tbl[1] = '{'{1'b1, 32'hBFAF_F004, 3'd0, 4'b0010, 128'h0000_0000_0000_0000_0000_0000_0000_5A00},
                   3'b010, 32'hBFAF_F004, 3'd0, 4'b0010};
        tbl[2] = '{'{1'b0, 32'h0000_204F, 3'd0, 4'h0, 128'hFFFF_0000_AAAA_5555_1234_5678_9ABC_DEF0},
                   3'b100, 32'h0000_2040, 3'd2, 4'hF};
        tbl[3] = '{'{1'b1, 32'h8000_0002, 3'd1, 4'b1100, 128'h0000_0000_0000_0000_0000_0000_BEEF_0000},
                   3'b010, 32'h8000_0002, 3'd1, 4'b1100};
        tbl[4] = '{'{1'b1, 32'h0000_0008, 3'd2, 4'hF, 128'h1111_2222_3333_4444_5555_6666_7777_8888},
                   3'b010, 32'h0000_0008, 3'd2, 4'hF};

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_push(tbl[i].e);
            data_wr_rdy = 1'b1;
            @(negedge clk);
            push_valid = 1'b0;
            wait_req();
            chk("tbl_type", data_wr_type, tbl[i].x_type);
            chk("tbl_addr", data_wr_addr, tbl[i].x_addr);
            chk("tbl_size", data_wr_size, tbl[i].x_size);
            chk("tbl_wstrb", data_wr_wstrb, tbl[i].x_wstrb);
            chk("tbl_data", data_wr_data, tbl[i].e.data);
            @(negedge clk);
            data_wr_rdy = 1'b0;
            chk("tbl_req_drop", data_wr_req, 1'b0);
            chk("tbl_busy", wb_empty, 1'b0);
            repeat (4) @(negedge clk);
            data_wr_ok = 1'b1;
            @(negedge clk);
            data_wr_ok = 1'b0;
            chk("tbl_empty", wb_empty, 1'b1);
            chk("tbl_ready", push_ready, 1'b1);
        end

        // Spurious ok while idle, then a request held off by the bridge
        @(negedge clk);
        data_wr_ok = 1'b1;
        @(negedge clk);
        data_wr_ok = 1'b0;
        chk("spur_empty", wb_empty, 1'b1);
        chk("spur_req", data_wr_req, 1'b0);
        drive_push('{1'b1, 32'h3000_0012, 3'd1, 4'b0011, 128'h77});
        @(negedge clk);
        push_valid = 1'b0;
        wait_req();
        for (int i = 0; i < 10; i++) begin
            data_wr_ok = (i == 5);
            @(negedge clk);
            chk("bp_req", data_wr_req, 1'b1);
            chk("bp_addr", data_wr_addr, 32'h3000_0012);
            chk("bp_wstrb", data_wr_wstrb, 4'b0011);
        end
        data_wr_ok = 1'b0;
        finish_one();
        chk("bp_done", wb_empty, 1'b1);

        // Fill to capacity with the bridge stalled; the 5th push waits for the first retire
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("fill_ready", push_ready, k < 4);
            drive_push('{1'b0, 32'(k + 1) << 12, 3'd0, 4'h0, 128'(k)});
        end
        repeat (3) begin
            @(negedge clk);
            chk("full_ready", push_ready, 1'b0);
        end
        got[0] = data_wr_addr;
        finish_one();
        chk("full_after_ok", push_ready, 1'b1);
        @(negedge clk);
        push_valid = 1'b0;
        chk("full_again", push_ready, 1'b0);
        for (int n = 1; n < 5; n++) begin
            wait_req();
            got[n] = data_wr_addr;
            finish_one();
            chk("gap_idle", data_wr_req, 1'b0);
        end
        for (int n = 0; n < 5; n++) chk("order", got[n], 32'(n + 1) << 12);
        chk("drain_empty", wb_empty, 1'b1);

        // Read-miss hazard detection
        @(negedge clk);
        drive_push('{1'b0, 32'h0000_2040, 3'd0, 4'h0, 128'h1});
        @(negedge clk);
        drive_push('{1'b1, 32'h0000_0008, 3'd2, 4'hF, 128'h2});
        @(negedge clk);
        push_valid = 1'b0;
        chk_addr = 32'h0000_204C; #1 chk("hz_line_hit", chk_hit, 1'b1);
        chk_addr = 32'h0000_2050; #1 chk("hz_line_miss", chk_hit, 1'b0);
        chk_addr = 32'h0000_000A; #1 chk("hz_word_hit", chk_hit, 1'b1);
        chk_addr = 32'h0000_000C; #1 chk("hz_word_miss", chk_hit, 1'b0);
        wait_req();
        finish_one();
        chk_addr = 32'h0000_204C; #1 chk("hz_line_gone", chk_hit, 1'b0);
        chk_addr = 32'h0000_000A; #1 chk("hz_word_still", chk_hit, 1'b1);
        wait_req();
        data_wr_rdy = 1'b1;
        @(negedge clk);
        data_wr_rdy = 1'b0;
        #1 chk("hz_inflight", chk_hit, 1'b1);
        data_wr_ok = 1'b1;
        @(negedge clk);
        data_wr_ok = 1'b0;
        #1 chk("hz_retired", chk_hit, 1'b0);

        // Asynchronous reset while a write is outstanding with three entries queued
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_push('{1'b0, 32'h5000_0000 + 32'(k * 16), 3'd0, 4'h0, 128'(k)});
        end
        @(negedge clk);
        push_valid = 1'b0;
        wait_req();
        data_wr_rdy = 1'b1;
        @(negedge clk);
        data_wr_rdy = 1'b0;
        chk("ar_busy", wb_empty, 1'b0);
        chk_addr = 32'h5000_0004;
        #1 chk("ar_hit_before", chk_hit, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("ar_req", data_wr_req, 1'b0);
        chk("ar_ready", push_ready, 1'b1);
        chk("ar_hit", chk_hit, 1'b0);
        chk("ar_empty", wb_empty, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive_push('{1'b1, 32'h4000_0000, 3'd2, 4'hF, 128'h9});
        @(negedge clk);
        push_valid = 1'b0;
        wait_req();
        chk("ar_post_addr", data_wr_addr, 32'h4000_0000);
        chk("ar_post_type", data_wr_type, 3'b010);
        finish_one();
        chk("ar_post_empty", wb_empty, 1'b1);

        // Randomized run against the queue model; the bench plays the bridge
        outstanding = 1'b0; prev_retire = 1'b0; timer = 0; stall = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            chk("rnd_ready", push_ready, q.size() < DEPTH);
            chk("rnd_empty", wb_empty, q.size() == 0);
            if (prev_retire) chk("rnd_gap", data_wr_req, 1'b0);
            stall = (q.size() != 0 && !outstanding && !data_wr_req) ? stall + 1 : 0;
            chk("rnd_stall", stall > 2, 1'b0);
            if (data_wr_req) begin
                chk("rnd_single", outstanding, 1'b0);
                chk("rnd_nonempty", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    chk("rnd_type", data_wr_type, m_type(q[0]));
                    chk("rnd_addr", data_wr_addr, m_addr(q[0]));
                    chk("rnd_size", data_wr_size, q[0].unc ? q[0].size : 3'd2);
                    chk("rnd_wstrb", data_wr_wstrb, q[0].unc ? q[0].wstrb : 4'hF);
                    chk("rnd_data", data_wr_data, q[0].data);
                end
            end
            e.unc   = 1'($urandom_range(0, 1));
            e.addr  = 32'($urandom_range(0, 255));
            e.size  = 3'($urandom_range(0, 2));
            e.wstrb = 4'($urandom);
            e.data  = {$urandom, $urandom, $urandom, $urandom};
            push_valid = $urandom_range(0, 1) == 1;
            push_uncached = e.unc; push_addr = e.addr; push_size = e.size;
            push_wstrb = e.wstrb; push_data = e.data;
            chk_addr    = 32'($urandom_range(0, 255));
            data_wr_rdy = $urandom_range(0, 1) == 1;
            data_wr_ok  = outstanding ? (timer == 0) : ($urandom_range(0, 7) == 0);
            #1 chk("rnd_hit", chk_hit, m_hit(chk_addr));
            grant  = data_wr_req && data_wr_rdy;
            retire = data_wr_ok && outstanding;
            pushed = push_valid && q.size() < DEPTH;
            if (outstanding && !retire) timer--;
            if (retire) begin
                void'(q.pop_front());
                outstanding = 1'b0;
            end
            if (pushed) q.push_back(e);
            if (grant) begin
                outstanding = 1'b1;
                timer = $urandom_range(0, 3);
            end
            prev_retire = retire;
        end
        @(negedge clk);
        push_valid = 1'b0; data_wr_ok = 1'b0; data_wr_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dcache_wb_buffer.md
Name: dcache_wb_buffer

Overview:
Write-back/store buffer between the data cache and the AXI bridge's data write port (data_wr_*). It queues evicted dirty lines (16 B bursts) and uncached word stores, then issues them to the bridge strictly in FIFO order, one at a time. Each entry is retired only when the bridge returns data_wr_ok. A combinational address-check port lets the dcache hold a read miss while a matching write is still buffered or in flight.

Parameters:
DEPTH, 4, number of entries; power of two, >=2
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state
push_valid  in  1  dcache offers an entry
push_ready  out  1  buffer can accept an entry
push_uncached  in  1  1 = single-word store, 0 = full-line writeback
push_addr  in  32  line address (low 4 bits ignored for lines) or word address
push_size  in  3  AXI size for uncached stores
push_wstrb  in  4  byte strobes for uncached stores
push_data  in  128  line data; bits [31:0] carry uncached store data
chk_addr  in  32  dcache read-miss address to check
chk_hit  out  1  chk_addr conflicts with a valid or in-flight entry
wb_empty  out  1  no valid entries and no transfer outstanding
data_wr_req  out  1  request to bridge
data_wr_type  out  3  3'b100 line, 3'b010 word
data_wr_addr  out  32  line: {addr[31:4],4'b0}; word: addr as pushed
data_wr_size  out  3  line: 3'd2; word: stored push_size
data_wr_wstrb  out  4  line: 4'b1111; word: stored push_wstrb
data_wr_data  out  128  entry data
data_wr_rdy  in  1  bridge accepts when req && rdy
data_wr_ok  in  1  one-cycle pulse: bridge write response received

Behaviour:
- Storage: DEPTH entries {uncached, addr, size, wstrb, data}, plus head and tail pointers (PTR_W bits, wrap mod DEPTH) and a count (PTR_W+1 bits, 0..DEPTH).
- Push: accepted on push_valid && push_ready. The entry is written at the tail, the tail increments and the count increments. push_ready = (count != DEPTH). It depends only on count: a slot freed by data_wr_ok becomes visible the following cycle.
- Issue FSM, one-hot:
  - S_IDLE: moves to S_REQ when count != 0.
  - S_REQ: data_wr_req = 1, with all data_wr_* fields driven combinationally from the head entry. On data_wr_rdy, moves to S_WAIT.
  - S_WAIT: data_wr_req = 0. On data_wr_ok: head increments, count decrements, and the FSM goes to S_IDLE.
- Only one bridge transaction is outstanding at any time. The head entry stays valid and unmodified until data_wr_ok.
- Minimum spacing between successive issues is 1 idle cycle (S_WAIT -> S_IDLE -> S_REQ).
- data_wr_ok outside S_WAIT is ignored.
- Push and retire in the same cycle: count is unchanged, both pointers advance. Push at full is refused regardless of a same-cycle retire.
- chk_hit is combinational over all valid entries, including the in-flight head:
  - line entry: match when chk_addr[31:4] == addr[31:4];
  - uncached entry: match when chk_addr[31:2] == addr[31:2].
  - chk_hit is 0 when count == 0.
- wb_empty = (count == 0) && S_IDLE.
- Reset values: count 0, head 0, tail 0, FSM S_IDLE, data_wr_req 0, push_ready 1, chk_hit 0, wb_empty 1. Entry payload registers need no reset.
- Reset mid-transfer abandons the outstanding write. The bridge is reset by the same reset.
- An illegal FSM encoding returns to S_IDLE.

Test Plan:
- Single line: push line addr 0x1000_0014, data 0x…DEAD_BEEF, rdy=1, ok 5 cycles after grant -> one data_wr_req with addr 0x1000_0010, type 3'b100, wstrb 4'b1111, size 3'd2. count returns to 0 and wb_empty=1 the cycle after ok.
- Uncached store: push addr 0xBFAF_F004, size 3'd0, wstrb 4'b0010 -> type 3'b010, addr 0xBFAF_F004, size 3'd0, wstrb 4'b0010.
- Fill/overflow: push 5 entries back-to-back with rdy=0 -> push_ready drops after the 4th. The 5th is held until the first ok and is accepted the cycle after it. Output order is 1..5.
- Backpressure: hold data_wr_rdy=0 for 10 cycles in S_REQ -> req stays high and all fields stay stable. A spurious ok pulse in S_IDLE changes nothing.
- Hazard check: buffer line 0x0000_2040; chk_addr 0x0000_204C -> hit=1; chk_addr 0x0000_2050 -> hit=0. With an uncached entry at 0x8 vs chk 0xA -> hit=1. hit stays 1 until that entry's ok.
- Async reset asserted in S_WAIT with count=3 -> outputs return to their reset values immediately (before the next edge). Pushes work normally after release.
